// File: rtl/booth_mul_seq.sv
// booth_mul_seq -- iterative radix-4 Booth multiplier, 8x8 -> 17-bit product.
//
// Scans one radix-4 Booth group of the (sign-extended) multiplier per cycle.
// Each group drives an internal partial-product selector. The selector returns
// a biased 10-bit partial product plus a negate bit, and the result is
// accumulated into a running sum. Operands and product move over valid/ready
// handshakes. The block sits between the PE operand fetch and the PE
// accumulator.
//
// Optional build macro: BOOTH_ZERO_SKIP_EN
//   When defined, the scan stops early once the remaining multiplier bits are
//   all-0 or all-1. Every remaining Booth code would then select zero. The
//   product is unchanged; only the latency shrinks to 1..5 edges.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   block can accept operands (registered)
//   a, a_sign  multiplicand and its signedness (1 = two's complement)
//   b, b_sign  multiplier and its signedness (1 = two's complement)
//   out_valid  product valid (registered)
//   out_ready  consumer accepts product
//   prod       17-bit two's-complement product (registered)
module booth_mul_seq #(
    parameter int GROUPS = 5,
    parameter int ACC_W  = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic        a_sign,
    input  logic [7:0]  b,
    input  logic        b_sign,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [16:0] prod
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth partial-product selector.
    // Returns {out_inv, out_data[9:0]}. out_data holds the selected multiple
    // with its sign bit inverted (a +512 bias). For negative multiples it is
    // the one's complement, and out_inv supplies the missing +1.
    function automatic logic [10:0] booth_sel(input logic [2:0] code,
                                              input logic [8:0] src);
        logic [9:0] mult;
        logic       inv;
        mult = 10'd0;
        inv  = 1'b0;
        case (code)
            3'b000, 3'b111: begin mult = 10'd0;              inv = 1'b0; end
            3'b001, 3'b010: begin mult = {src[8], src};      inv = 1'b0; end
            3'b011:         begin mult = {src, 1'b0};        inv = 1'b0; end
            3'b100:         begin mult = ~{src, 1'b0};       inv = 1'b1; end
            3'b101, 3'b110: begin mult = ~{src[8], src};     inv = 1'b1; end
            default:        begin mult = 10'd0;              inv = 1'b0; end
        endcase
        return {inv, mult ^ 10'h200};
    endfunction

    state_t            state_r, state_n;
    logic [8:0]        a_ext_r, a_ext_n;
    logic [9:0]        b_ext_r, b_ext_n;
    logic [ACC_W-1:0]  acc_r, acc_n;
    logic [2:0]        cnt_r, cnt_n;
    logic [16:0]       prod_r, prod_n;
    logic              out_valid_r, out_valid_n;
    logic              in_ready_r, in_ready_n;

    logic [10:0]       bx_s;
    logic [2:0]        code_s;
    logic [10:0]       sel_s;
    logic [ACC_W-1:0]  pp_s;
    logic [ACC_W-1:0]  term_s;
    logic [ACC_W-1:0]  sum_s;
    logic              last_s;
    logic              finish_s;

    // Group selection: b_ext with the implicit b_ext[-1]=0 appended at the LSB.
    assign bx_s   = {b_ext_r, 1'b0};
    assign code_s = 3'(bx_s >> {cnt_r, 1'b0});
    assign sel_s  = booth_sel(code_s, a_ext_r);

    // Remove the +512 bias by re-inverting the sign bit. Then sign-extend and
    // add the negate bit to form the exact signed partial product.
    assign pp_s   = {{(ACC_W-10){~sel_s[9]}}, ~sel_s[9], sel_s[8:0]}
                  + {{(ACC_W-1){1'b0}}, sel_s[10]};
    assign term_s = pp_s << {cnt_r, 1'b0};
    assign sum_s  = acc_r + term_s;
    assign last_s = (cnt_r == 3'(GROUPS - 1));

`ifdef BOOTH_ZERO_SKIP_EN
    logic [3:0] shamt_s;
    logic [9:0] rem_s;
    // Arithmetic shift leaves only b_ext[9:2cnt+1], padded with copies of b_ext[9].
    // The result is all-0 or all-1 exactly when the remaining groups are all zero.
    assign shamt_s  = {cnt_r, 1'b0} + 4'd1;
    assign rem_s    = $signed(b_ext_r) >>> shamt_s;
    assign finish_s = last_s || (rem_s == 10'h000) || (rem_s == 10'h3FF);
`else
    assign finish_s = last_s;
`endif

    // Next-state and next-register logic for the control FSM and datapath.
    always_comb begin
        state_n     = state_r;
        a_ext_n     = a_ext_r;
        b_ext_n     = b_ext_r;
        acc_n       = acc_r;
        cnt_n       = cnt_r;
        prod_n      = prod_r;
        out_valid_n = out_valid_r;
        in_ready_n  = in_ready_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    a_ext_n    = {a_sign & a[7], a};
                    b_ext_n    = {{2{b_sign & b[7]}}, b};
                    acc_n      = {ACC_W{1'b0}};
                    cnt_n      = 3'd0;
                    in_ready_n = 1'b0;
                    state_n    = RUN;
                end else begin
                    in_ready_n = 1'b1;
                end
            end
            RUN: begin
                acc_n = sum_s;
                if (finish_s) begin
                    prod_n      = sum_s[16:0];
                    out_valid_n = 1'b1;
                    state_n     = DONE;
                end else begin
                    cnt_n = cnt_r + 3'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    in_ready_n  = 1'b1;
                    state_n     = IDLE;
                end else begin
                    out_valid_n = 1'b1;
                end
            end
            default: begin
                out_valid_n = 1'b0;
                in_ready_n  = 1'b1;
                state_n     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            a_ext_r     <= 9'd0;
            b_ext_r     <= 10'd0;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= 3'd0;
            prod_r      <= 17'd0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_n;
            a_ext_r     <= a_ext_n;
            b_ext_r     <= b_ext_n;
            acc_r       <= acc_n;
            cnt_r       <= cnt_n;
            prod_r      <= prod_n;
            out_valid_r <= out_valid_n;
            in_ready_r  <= in_ready_n;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign prod      = prod_r;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: a scoreboard queue fed at issue time,
// drained by an independent monitor on every output handshake.
module tb_booth_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic        a_sign;
    logic [7:0]  b;
    logic        b_sign;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] prod;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    booth_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .a_sign    (a_sign),
        .b         (b),
        .b_sign    (b_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod)
    );

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: plain integer multiplication of the operands as interpreted.
    function automatic int ref_mul(input logic [7:0] x, input logic xs,
                                   input logic [7:0] y, input logic ys);
        int xv;
        int yv;
        xv = xs ? int'($signed(x)) : int'(x);
        yv = ys ? int'($signed(y)) : int'(y);
        return xv * yv;
    endfunction

    // Expected edges from acceptance to out_valid.
    function automatic int exp_lat(input logic [7:0] y, input logic ys);
`ifdef BOOTH_ZERO_SKIP_EN
        logic [9:0] bx;
        bit         uni;
        bx = {{2{ys & y[7]}}, y};
        for (int g = 0; g < 5; g++) begin
            uni = 1'b1;
            for (int k = 2 * g + 1; k <= 9; k++) begin
                if (bx[k] != bx[9]) uni = 1'b0;
            end
            if (uni) return g + 1;
        end
        return 5;
`else
        return 5;
`endif
    endfunction

    // Monitor: compare on every completed output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_output", exp_q.size(), 1);
            else chk("prod", $signed(prod), exp_q.pop_front());
        end
    end

    // Issue one operation; returns with out_valid high (or timed out). If
    // out_ready is high, also steps past the handshake edge back to IDLE.
    task automatic do_op(input logic [7:0] xa, input logic xas,
                         input logic [7:0] xb, input logic xbs, input bit chk_l);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
        if (!in_ready) chk("in_ready_timeout", in_ready, 1);
        a = xa; a_sign = xas; b = xb; b_sign = xbs; in_valid = 1'b1;
        exp_q.push_back(ref_mul(xa, xas, xb, xbs));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (chk_l) chk("latency", lat, exp_lat(xb, xbs));
        if (out_ready) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 8'd0; a_sign = 1'b0; b = 8'd0; b_sign = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_prod", prod, 0);

        // Directed corner products.
        do_op(8'h80, 1'b1, 8'h80, 1'b1, 1'b1);   //  16384
        do_op(8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1);   //  65025
        do_op(8'h80, 1'b1, 8'hFF, 1'b0, 1'b1);   // -32640
        do_op(8'h7F, 1'b1, 8'hFF, 1'b1, 1'b1);   // -127
        do_op(8'd7,  1'b0, 8'd1,  1'b0, 1'b1);   //  7
        do_op(8'd0,  1'b1, 8'h80, 1'b1, 1'b1);   //  0

        // Backpressure: product and flags hold; in_valid outside IDLE is ignored.
        out_ready = 1'b0;
        do_op(8'd3, 1'b0, 8'd5, 1'b0, 1'b1);
        a = 8'd9; b = 8'd9; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_prod", prod, 15);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_in_ready", in_ready, 1);
        chk("bp_idle_out_valid", out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("ignored_in_ready", in_ready, 1);
        chk("ignored_out_valid", out_valid, 0);

        // Reset in RUN at cnt=2; the aborted op must produce nothing.
        a = 8'd100; a_sign = 1'b0; b = 8'h55; b_sign = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        do_op(8'd3, 1'b0, 8'd5, 1'b0, 1'b1);

        // Randomized operands and sign modes.
        for (int n = 0; n < 400; n++) begin
            do_op(8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
